dmem_arbiter: RTL
=================

# dmem_arbiter

Shares the single-port data memory between the pipeline MEM stage (CPU port) and a debug/loader port that preloads and inspects memory while the core runs. Arbitrates each cycle, drives the memory port, returns read data one cycle after the grant, and raises `cpu_stall` so the pipeline freezes its first stages when the MEM stage loses a cycle. It sits between the EX/MEM pipeline register and `DMemory`.

## Interface
- `ADDR_W`, 10, word-index width; memory holds 2^ADDR_W 32-bit words.
- `DATA_W`, 32, data word width.
- `MAX_WAIT`, 4, number of lost cycles after which the debug port gets priority. Range 1..15.

- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `cpu_req`  in  1  MEM-stage access request; LD or SD in EX/MEM.
- `cpu_we`  in  1  1 = store, 0 = load.
- `cpu_addr`  in  64  byte address, the ALU output in EX/MEM.
- `cpu_wdata`  in  DATA_W  store data, from EX/MEM B.
- `cpu_gnt`  out  1  CPU access performed this cycle.
- `cpu_stall`  out  1  `cpu_req & ~cpu_gnt`.
- `cpu_rvalid`  out  1  CPU read data valid.
- `cpu_rdata`  out  DATA_W  CPU read data.
- `dbg_req`, `dbg_we`, `dbg_addr[63:0]`, `dbg_wdata[DATA_W-1:0]`  in  debug request. Same meaning as the CPU inputs.
- `dbg_gnt`, `dbg_rvalid`, `dbg_rdata[DATA_W-1:0]`  out  debug response. Same meaning as the CPU outputs.
- `mem_en`  out  1  memory access strobe.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  ADDR_W  word index.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_rdata`  in  DATA_W  synchronous-read data, valid the cycle after `mem_en & ~mem_we`.
- `err_misaligned`  out  1  sticky misaligned-access flag.

## Operation
- **Request rule.** A requester holds `req`, `we`, `addr` and `wdata` stable until it sees `gnt`.
- **Arbitration.** Combinational each cycle.
  - Only one port requesting: that port wins.
  - Both ports requesting: CPU wins, except when the wait counter is at `MAX_WAIT`; then debug wins.
- **Memory port.**
  - `mem_en` is high for the winner unless its access is misaligned.
  - `mem_addr = addr[ADDR_W+1:2]`. Upper address bits are ignored, so addresses wrap modulo memory size.
  - `mem_we` follows the winner's `we`. `mem_wdata` follows the winner's `wdata`.
- **Wait counter** (4 bits, `wait_cnt`).
  - Increments, saturating at `MAX_WAIT`, on each cycle with `dbg_req & ~dbg_gnt`.
  - Clears on `dbg_gnt`.
  - Holds otherwise.
- **Read return.** On a granted read, register the owner (`rd_pend`, `rd_owner`, `rd_bad`).
  - Next cycle: the owner's `rvalid` = 1.
  - Owner's `rdata` = `mem_rdata`, or 0 if `rd_bad`.
  - The other port's `rdata` is 0.
- **Misaligned access** (`addr[1:0] != 0`).
  - Still granted and consumes the cycle.
  - `mem_en` is forced low, so no write occurs.
  - A read returns `rvalid` with data 0.
  - `err_misaligned` sets and stays set until reset.
- **Reset (asynchronous, any time).**
  - `wait_cnt` = 0.
  - `rd_pend` = 0, so both `rvalid` outputs are 0 and any in-flight read is discarded.
  - `err_misaligned` = 0.
  - Combinational outputs are 0 while `reset_n` = 0: `gnt`, `mem_en`, `mem_we`, `cpu_stall`.

## Timing
- Grant latency: 0 cycles; `gnt` is asserted in the same cycle as `req`.
- Write latency: the memory is updated on the edge that ends the grant cycle.
- Read latency: `rvalid` is asserted one cycle after `gnt`, for exactly one cycle.
- Back-to-back grants to either port are allowed every cycle, with reads overlapping returns.
- Starvation bound: the debug port is granted no later than `MAX_WAIT`+1 cycles after raising `dbg_req`.
- Worst-case CPU stall: 1 cycle per debug win.
- `cpu_stall` is combinational. The pipeline samples it at the rising edge to freeze IF/ID/EX and inject a NOP into MEM/WB.

## Configuration
- `DMEM_ARB_FAIR_EN`.
  - Defined: the wait counter and debug-priority override exist as described.
  - Undefined: fixed CPU priority; `wait_cnt` is removed; debug is granted only in cycles with `cpu_req` = 0, and can starve indefinitely.
  - All other behaviour is identical in both builds.

## Test plan
- **Reset.** Assert `reset_n` = 0 with `cpu_req` = `dbg_req` = 1.
  - While low: every `gnt`/`rvalid` = 0, `mem_en` = 0.
  - After release: `cpu_gnt` = 1 in the same cycle.
- **CPU store then load.** CPU store 0x1234 at byte addr 0x10, then a CPU load from 0x10.
  - Store cycle: `mem_addr` = 4, `mem_we` = 1.
  - Load: `cpu_rvalid` = 1 with `cpu_rdata` = 0x1234 one cycle after its grant.
- **Contention.** Both ports request continuously, `MAX_WAIT` = 4, `DMEM_ARB_FAIR_EN` defined.
  - Debug is granted on the 5th cycle; `cpu_stall` = 1 in exactly that cycle.
  - The pattern repeats every 5 cycles.
- **Fair disabled.** Same stimulus without `DMEM_ARB_FAIR_EN`.
  - `dbg_gnt` never asserts while `cpu_req` = 1.
  - Debug is granted in the first cycle `cpu_req` drops.
- **Misaligned.** CPU load at addr 0x13.
  - `cpu_gnt` = 1, `mem_en` = 0, `cpu_rvalid` = 1 with data 0 next cycle, `err_misaligned` = 1 and remains set.
- **Reset mid-read / wrap.** Assert `reset_n` low in the cycle after a granted read.
  - `cpu_rvalid` = 0.
- **Address wrap.** Debug store at addr 0x1000 with `ADDR_W` = 10.
  - `mem_addr` = 0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the MEM-stage CPU
// port and a debug/loader port.
// The grant and memory-port outputs are combinational, same cycle as the request.
// Read data returns one cycle after the grant.
// Optional macro DMEM_ARB_FAIR_EN: when defined, a wait counter gives the debug
// port priority after MAX_WAIT lost cycles. When undefined, the CPU always has
// priority.
module dmem_arbiter #(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [63:0]       cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [63:0]       dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err_misaligned
);

    localparam int unsigned CNT_W = 4;

    logic              dbg_prio;
    logic              any_gnt;
    logic              sel_we;
    logic              sel_mis;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              rd_pend;
    logic              rd_owner;   // 1 = debug port owns the pending read
    logic              rd_bad;
    logic              unused_addr_bits;

    // Upper address bits are ignored: addresses wrap modulo the memory size
    assign unused_addr_bits = ^{cpu_addr[63:ADDR_W+2], dbg_addr[63:ADDR_W+2]};

`ifdef DMEM_ARB_FAIR_EN
    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] wait_cnt;

    // Count cycles the debug port loses; clear when it wins
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= '0;
        end else if (dbg_gnt) begin
            wait_cnt <= '0;
        end else if (dbg_req && (wait_cnt != WAIT_LIMIT)) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    assign dbg_prio = (wait_cnt == WAIT_LIMIT);
`else
    assign dbg_prio = 1'b0;
`endif

    // Arbitration and memory-port steering, all forced idle during reset
    always_comb begin
        cpu_gnt   = 1'b0;
        dbg_gnt   = 1'b0;
        sel_we    = 1'b0;
        sel_mis   = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        if (reset_n) begin
            if (cpu_req && !(dbg_req && dbg_prio)) begin
                cpu_gnt = 1'b1;
            end else if (dbg_req) begin
                dbg_gnt = 1'b1;
            end
        end
        if (cpu_gnt) begin
            sel_we    = cpu_we;
            sel_mis   = (cpu_addr[1:0] != 2'b00);
            sel_addr  = cpu_addr[ADDR_W+1:2];
            sel_wdata = cpu_wdata;
        end else if (dbg_gnt) begin
            sel_we    = dbg_we;
            sel_mis   = (dbg_addr[1:0] != 2'b00);
            sel_addr  = dbg_addr[ADDR_W+1:2];
            sel_wdata = dbg_wdata;
        end
    end

    assign any_gnt   = cpu_gnt | dbg_gnt;
    assign cpu_stall = cpu_req & ~cpu_gnt & reset_n;
    assign mem_en    = any_gnt & ~sel_mis;
    assign mem_we    = any_gnt & sel_we;
    assign mem_addr  = sel_addr;
    assign mem_wdata = sel_wdata;

    // Track the owner of a granted read so data can be routed next cycle
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_pend  <= 1'b0;
            rd_owner <= 1'b0;
            rd_bad   <= 1'b0;
        end else begin
            rd_pend  <= any_gnt & ~sel_we;
            rd_owner <= dbg_gnt;
            rd_bad   <= sel_mis;
        end
    end

    // Sticky misaligned-access flag
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_misaligned <= 1'b0;
        end else if (any_gnt && sel_mis) begin
            err_misaligned <= 1'b1;
        end
    end

    assign cpu_rvalid = rd_pend & ~rd_owner;
    assign dbg_rvalid = rd_pend & rd_owner;
    assign cpu_rdata  = (cpu_rvalid && !rd_bad) ? mem_rdata : '0;
    assign dbg_rdata  = (dbg_rvalid && !rd_bad) ? mem_rdata : '0;

endmodule
